// File: rtl/ccc_stream_decoder.sv
// ccc_stream_decoder: turns a raster-ordered stream of CCC blocks into a
// raster-ordered stream of 24-bit RGB pixels. One block row is buffered
// per bank of a two-bank ping-pong store, so block input overlaps pixel output.
module ccc_stream_decoder #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        frame_done
);

    localparam int NB    = WIDTH / 4;
    localparam int NBY   = HEIGHT / 4;
    localparam int BXW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int BYW   = (NBY > 1) ? $clog2(NBY) : 1;
    localparam int DEPTH = 2 * (1 << BXW);

    if ((WIDTH % 4) != 0 || (HEIGHT % 4) != 0) begin : g_bad_size
        $error("ccc_stream_decoder: WIDTH and HEIGHT must be multiples of 4");
    end

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    logic           s_ready_q, s_ready_d;
    logic           wr_bank_q, wr_bank_d;
    logic [BXW-1:0] wr_bx_q, wr_bx_d;
    // read-side pixel counters: bank, block column, column in block, row in block, block row
    logic           rd_active_q, rd_active_d;
    logic           rd_bank_q, rd_bank_d;
    logic [BXW-1:0] rd_bx_q, rd_bx_d;
    logic [1:0]     rd_c_q, rd_c_d;
    logic [1:0]     rd_r_q, rd_r_d;
    logic [BYW-1:0] rd_by_q, rd_by_d;
    // stage 0: RAM address stage
    logic           p0_v_q, p0_v_d, p0_bank_q, p0_bank_d;
    logic [BXW-1:0] p0_bx_q, p0_bx_d;
    logic [1:0]     p0_c_q, p0_c_d, p0_r_q, p0_r_d;
    logic           p0_sof_q, p0_sof_d, p0_eol_q, p0_eol_d;
    logic           p0_lb_q, p0_lb_d, p0_lf_q, p0_lf_d;
    // stage 1: RAM data stage
    logic           p1_v_q, p1_v_d, p1_bank_q, p1_bank_d;
    logic [1:0]     p1_c_q, p1_c_d, p1_r_q, p1_r_d;
    logic           p1_sof_q, p1_sof_d, p1_eol_q, p1_eol_d;
    logic           p1_lb_q, p1_lb_d, p1_lf_q, p1_lf_d;
    // output register
    logic           m_valid_q, m_valid_d;
    logic [23:0]    m_data_q, m_data_d;
    logic           m_sof_q, m_sof_d, m_eol_q, m_eol_d;
    logic           m_lb_q, m_lb_d, m_lf_q, m_lf_d, m_bank_q, m_bank_d;
    logic           frame_done_q, frame_done_d;

    logic [63:0]    mem [DEPTH];
    logic [63:0]    ram_rd_q;

    logic s_fire_s, m_fire_s, advance_s, issue_s, rd_last_s, pix_bit_s;

    // Next-state logic for bank states, counters and the pixel pipeline.
    always_comb begin
        bank_d        = bank_q;
        wr_bank_d     = wr_bank_q;
        wr_bx_d       = wr_bx_q;
        rd_active_d   = rd_active_q;
        rd_bank_d     = rd_bank_q;
        rd_bx_d       = rd_bx_q;
        rd_c_d        = rd_c_q;
        rd_r_d        = rd_r_q;
        rd_by_d       = rd_by_q;
        p0_v_d = p0_v_q; p0_bank_d = p0_bank_q; p0_bx_d = p0_bx_q;
        p0_c_d = p0_c_q; p0_r_d = p0_r_q; p0_sof_d = p0_sof_q;
        p0_eol_d = p0_eol_q; p0_lb_d = p0_lb_q; p0_lf_d = p0_lf_q;
        p1_v_d = p1_v_q; p1_bank_d = p1_bank_q; p1_c_d = p1_c_q;
        p1_r_d = p1_r_q; p1_sof_d = p1_sof_q; p1_eol_d = p1_eol_q;
        p1_lb_d = p1_lb_q; p1_lf_d = p1_lf_q;
        m_valid_d = m_valid_q; m_data_d = m_data_q; m_sof_d = m_sof_q;
        m_eol_d = m_eol_q; m_lb_d = m_lb_q; m_lf_d = m_lf_q; m_bank_d = m_bank_q;

        s_fire_s  = s_valid && s_ready_q;
        m_fire_s  = m_valid_q && m_ready;
        // whole pipeline moves together whenever the output slot frees up
        advance_s = !m_valid_q || m_ready;
        rd_last_s = (rd_bx_q == BXW'(NB - 1)) && (rd_c_q == 2'd3) && (rd_r_q == 2'd3);
        issue_s   = advance_s && (rd_active_q || (bank_q[rd_bank_q] == BANK_FULL));
        pix_bit_s = ram_rd_q[{p1_r_q, p1_c_q}];

        // write side: store the block, close the bank on the last block of the row
        if (s_fire_s) begin
            if (wr_bx_q == BXW'(NB - 1)) begin
                bank_d[wr_bank_q] = BANK_FULL;
                wr_bank_d         = ~wr_bank_q;
                wr_bx_d           = '0;
            end else begin
                bank_d[wr_bank_q] = BANK_FILLING;
                wr_bx_d           = wr_bx_q + BXW'(1);
            end
        end else begin
            wr_bx_d = wr_bx_q;
        end

        // read side: walk r 0..3, x 0..WIDTH-1; chain straight into the other bank if it is ready
        if (issue_s) begin
            if (!rd_active_q) begin
                bank_d[rd_bank_q] = BANK_DRAINING;
                rd_active_d       = 1'b1;
            end else begin
                rd_active_d = 1'b1;
            end
            if (rd_last_s) begin
                rd_bx_d   = '0;
                rd_c_d    = 2'd0;
                rd_r_d    = 2'd0;
                rd_bank_d = ~rd_bank_q;
                rd_by_d   = (rd_by_q == BYW'(NBY - 1)) ? '0 : rd_by_q + BYW'(1);
                if (bank_q[~rd_bank_q] == BANK_FULL) begin
                    bank_d[~rd_bank_q] = BANK_DRAINING;
                    rd_active_d        = 1'b1;
                end else begin
                    rd_active_d = 1'b0;
                end
            end else if (rd_c_q == 2'd3) begin
                rd_c_d = 2'd0;
                if (rd_bx_q == BXW'(NB - 1)) begin
                    rd_bx_d = '0;
                    rd_r_d  = rd_r_q + 2'd1;
                end else begin
                    rd_bx_d = rd_bx_q + BXW'(1);
                end
            end else begin
                rd_c_d = rd_c_q + 2'd1;
            end
        end else begin
            rd_active_d = rd_active_q;
        end

        // a bank is free again once its final pixel has left the output port
        if (m_fire_s && m_lb_q) begin
            bank_d[m_bank_q] = BANK_EMPTY;
        end else begin
            m_lb_d = m_lb_q;
        end

        s_ready_d = (bank_d[wr_bank_d] == BANK_EMPTY) || (bank_d[wr_bank_d] == BANK_FILLING);

        if (advance_s) begin
            p0_v_d    = issue_s;
            p0_bank_d = rd_bank_q;
            p0_bx_d   = rd_bx_q;
            p0_c_d    = rd_c_q;
            p0_r_d    = rd_r_q;
            p0_sof_d  = (rd_by_q == '0) && (rd_r_q == 2'd0) && (rd_bx_q == '0) && (rd_c_q == 2'd0);
            p0_eol_d  = (rd_bx_q == BXW'(NB - 1)) && (rd_c_q == 2'd3);
            p0_lb_d   = rd_last_s;
            p0_lf_d   = rd_last_s && (rd_by_q == BYW'(NBY - 1));
            p1_v_d = p0_v_q; p1_bank_d = p0_bank_q; p1_c_d = p0_c_q; p1_r_d = p0_r_q;
            p1_sof_d = p0_sof_q; p1_eol_d = p0_eol_q; p1_lb_d = p0_lb_q; p1_lf_d = p0_lf_q;
            m_valid_d = p1_v_q;
            if (p1_v_q) begin
                m_data_d = pix_bit_s ? ram_rd_q[39:16] : ram_rd_q[63:40];
                m_sof_d  = p1_sof_q;
                m_eol_d  = p1_eol_q;
                m_lb_d   = p1_lb_q;
                m_lf_d   = p1_lf_q;
                m_bank_d = p1_bank_q;
            end else begin
                m_data_d = m_data_q;
            end
        end else begin
            p0_v_d = p0_v_q;
        end

        frame_done_d = m_fire_s && m_lf_q;
    end

    // Control and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= BANK_EMPTY;  bank_q[1] <= BANK_EMPTY;
            s_ready_q <= 1'b0; wr_bank_q <= 1'b0; wr_bx_q <= '0;
            rd_active_q <= 1'b0; rd_bank_q <= 1'b0; rd_bx_q <= '0;
            rd_c_q <= 2'd0; rd_r_q <= 2'd0; rd_by_q <= '0;
            p0_v_q <= 1'b0; p0_bank_q <= 1'b0; p0_bx_q <= '0; p0_c_q <= 2'd0;
            p0_r_q <= 2'd0; p0_sof_q <= 1'b0; p0_eol_q <= 1'b0; p0_lb_q <= 1'b0; p0_lf_q <= 1'b0;
            p1_v_q <= 1'b0; p1_bank_q <= 1'b0; p1_c_q <= 2'd0; p1_r_q <= 2'd0;
            p1_sof_q <= 1'b0; p1_eol_q <= 1'b0; p1_lb_q <= 1'b0; p1_lf_q <= 1'b0;
            m_valid_q <= 1'b0; m_data_q <= 24'd0; m_sof_q <= 1'b0; m_eol_q <= 1'b0;
            m_lb_q <= 1'b0; m_lf_q <= 1'b0; m_bank_q <= 1'b0; frame_done_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            s_ready_q <= s_ready_d; wr_bank_q <= wr_bank_d; wr_bx_q <= wr_bx_d;
            rd_active_q <= rd_active_d; rd_bank_q <= rd_bank_d; rd_bx_q <= rd_bx_d;
            rd_c_q <= rd_c_d; rd_r_q <= rd_r_d; rd_by_q <= rd_by_d;
            p0_v_q <= p0_v_d; p0_bank_q <= p0_bank_d; p0_bx_q <= p0_bx_d; p0_c_q <= p0_c_d;
            p0_r_q <= p0_r_d; p0_sof_q <= p0_sof_d; p0_eol_q <= p0_eol_d; p0_lb_q <= p0_lb_d; p0_lf_q <= p0_lf_d;
            p1_v_q <= p1_v_d; p1_bank_q <= p1_bank_d; p1_c_q <= p1_c_d; p1_r_q <= p1_r_d;
            p1_sof_q <= p1_sof_d; p1_eol_q <= p1_eol_d; p1_lb_q <= p1_lb_d; p1_lf_q <= p1_lf_d;
            m_valid_q <= m_valid_d; m_data_q <= m_data_d; m_sof_q <= m_sof_d; m_eol_q <= m_eol_d;
            m_lb_q <= m_lb_d; m_lf_q <= m_lf_d; m_bank_q <= m_bank_d; frame_done_q <= frame_done_d;
        end
    end

    // Block store: write on accept, synchronous read that holds while the pipeline stalls.
    always_ff @(posedge clk) begin
        if (s_fire_s) begin
            mem[{wr_bank_q, wr_bx_q}] <= s_data;
        end
        if (advance_s) begin
            ram_rd_q <= mem[{p0_bank_q, p0_bx_q}];
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_sof      = m_sof_q;
    assign m_eol      = m_eol_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ccc_stream_decoder.sv
// Scoreboard bench for ccc_stream_decoder: a 4x4 and a 16x16 instance share
// clock and reset; feeders drain block queues, monitors pop expected pixels.
module tb_ccc_stream_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        s_valid4, s_ready4, m_valid4, m_ready4, m_sof4, m_eol4, fd4;
    logic [63:0] s_data4;
    logic [23:0] m_data4;
    logic        s_valid16, s_ready16, m_valid16, m_ready16, m_sof16, m_eol16, fd16;
    logic [63:0] s_data16;
    logic [23:0] m_data16;

    ccc_stream_decoder #(.WIDTH(4), .HEIGHT(4)) u_dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4), .m_sof(m_sof4),
        .m_eol(m_eol4), .frame_done(fd4));

    ccc_stream_decoder #(.WIDTH(16), .HEIGHT(16)) u_dut16 (
        .clk(clk), .rst(rst), .s_valid(s_valid16), .s_ready(s_ready16), .s_data(s_data16),
        .m_valid(m_valid16), .m_ready(m_ready16), .m_data(m_data16), .m_sof(m_sof16),
        .m_eol(m_eol16), .frame_done(fd16));

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [63:0] blk_q4[$], blk_q16[$];
    logic [26:0] exp_q4[$], exp_q16[$];   // {last_of_frame, sof, eol, rgb}
    int  acc4 = 0, acc16 = 0, pop4 = 0, pop16 = 0, fd_cnt4 = 0, fd_cnt16 = 0;
    int  acc_cyc4 = 0, rmode4 = 0, rmode16 = 0, lim16 = 0;
    bit  fire_pend4 = 0, fire_pend16 = 0, lat_arm4 = 0;
    bit  hold4 = 0, hold16 = 0, fd_pend4 = 0, fd_pend16 = 0;
    logic [25:0] hold_v4, hold_v16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // m_ready drivers, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        m_ready4  = (rmode4 == 2) ? 1'($urandom_range(0, 1)) : (rmode4 == 1);
        m_ready16 = (rmode16 == 1) && (pop16 < lim16);
    end

    // block feeders: a handshake decided at one negedge is retired at the next
    always @(negedge clk) begin
        if (fire_pend4 && blk_q4.size() > 0) begin
            void'(blk_q4.pop_front()); acc4++; acc_cyc4 = cyc;
        end
        if (blk_q4.size() > 0) begin s_valid4 = 1'b1; s_data4 = blk_q4[0]; end
        else begin s_valid4 = 1'b0; end
        fire_pend4 = s_valid4 && s_ready4 && !rst;
        if (fire_pend16 && blk_q16.size() > 0) begin
            void'(blk_q16.pop_front()); acc16++;
        end
        if (blk_q16.size() > 0) begin s_valid16 = 1'b1; s_data16 = blk_q16[0]; end
        else begin s_valid16 = 1'b0; end
        fire_pend16 = s_valid16 && s_ready16 && !rst;
    end

    // monitor for the 4x4 instance
    always @(negedge clk) begin
        logic [26:0] e;
        if (fd4) fd_cnt4++;
        if (fd_pend4) begin check("frame_done4", {31'd0, fd4}, 32'd1); fd_pend4 = 0; end
        if (hold4) check("hold_stable4", {m_valid4, m_sof4, m_eol4, m_data4}, {1'b1, hold_v4});
        if (lat_arm4 && m_valid4) begin
            check("latency4", cyc - acc_cyc4, 32'd3); lat_arm4 = 0;
        end
        if (m_valid4 && m_ready4) begin
            if (exp_q4.size() == 0) check("extra_pixel4", {8'd0, m_data4}, 32'hFFFFFFFF);
            else begin
                e = exp_q4.pop_front();
                check("pixel4", {m_sof4, m_eol4, m_data4}, e[25:0]);
                fd_pend4 = e[26]; pop4++;
            end
        end
        hold4 = m_valid4 && !m_ready4;
        hold_v4 = {m_sof4, m_eol4, m_data4};
    end

    // monitor for the 16x16 instance
    always @(negedge clk) begin
        logic [26:0] e;
        if (fd16) fd_cnt16++;
        if (fd_pend16) begin check("frame_done16", {31'd0, fd16}, 32'd1); fd_pend16 = 0; end
        if (hold16) check("hold_stable16", {m_valid16, m_sof16, m_eol16, m_data16}, {1'b1, hold_v16});
        if (m_valid16 && m_ready16) begin
            if (exp_q16.size() == 0) check("extra_pixel16", {8'd0, m_data16}, 32'hFFFFFFFF);
            else begin
                e = exp_q16.pop_front();
                check("pixel16", {m_sof16, m_eol16, m_data16}, e[25:0]);
                fd_pend16 = e[26]; pop16++;
            end
        end
        hold16 = m_valid16 && !m_ready16;
        hold_v16 = {m_sof16, m_eol16, m_data16};
    end

    // the directed 4x4 block and its hand-decoded pixels (B=0000FF, R=FF0000)
    task automatic push_t1();
        logic [23:0] px [16];
        px = '{24'h0000FF, 24'hFF0000, 24'h0000FF, 24'hFF0000,
               24'hFF0000, 24'h0000FF, 24'hFF0000, 24'h0000FF,
               24'h0000FF, 24'hFF0000, 24'h0000FF, 24'hFF0000,
               24'hFF0000, 24'h0000FF, 24'hFF0000, 24'h0000FF};
        blk_q4.push_back({24'hFF0000, 24'h0000FF, 16'hA5A5});
        for (int i = 0; i < 16; i++)
            exp_q4.push_back({1'(i == 15), 1'(i == 0), 1'(i % 4 == 3), px[i]});
    endtask

    // a 16x16 frame of random blocks; the first nblk are offered
    task automatic push_frame16(input int nblk);
        logic [63:0] f [16];
        logic [63:0] b;
        logic        bitv;
        for (int i = 0; i < 16; i++) f[i] = {$urandom(), $urandom()};
        for (int i = 0; i < nblk; i++) blk_q16.push_back(f[i]);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                b = f[(y / 4) * 4 + x / 4];
                bitv = b[(y % 4) * 4 + x % 4];
                exp_q16.push_back({1'(x == 15 && y == 15), 1'(x == 0 && y == 0), 1'(x == 15),
                                   bitv ? b[39:16] : b[63:40]});
            end
        end
    endtask

    task automatic drain(input bit sel16, input string name);
        int n = 0;
        while (((sel16 ? exp_q16.size() : exp_q4.size()) != 0) && n < 4000) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        check(name, {31'd0, n < 4000}, 32'd1);
    endtask

    initial begin
        int n, gaps;
        rst = 1'b0; s_valid4 = 1'b0; s_valid16 = 1'b0; s_data4 = '0; s_data16 = '0;
        m_ready4 = 1'b0; m_ready16 = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_outputs4", {6'd0, s_ready4, m_valid4, m_sof4, m_eol4, fd4, m_data4}, 32'd0);
        check("reset_outputs16", {27'd0, s_ready16, m_valid16, m_sof16, m_eol16, fd16}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_reset", {30'd0, s_ready4, s_ready16}, 32'd3);

        // test 1: single 4x4 block, m_ready held high
        rmode4 = 1; lat_arm4 = 1;
        push_t1();
        drain(1'b0, "t1_drain");
        check("t1_latency_seen", {31'd0, lat_arm4}, 32'd0);

        // test 2: same block, random backpressure
        rmode4 = 2;
        push_t1();
        drain(1'b0, "t2_drain");

        // tests 3/5: two 16x16 frames back-to-back at full rate
        rmode16 = 1; lim16 = 32'h3FFFFFFF;
        push_frame16(16);
        push_frame16(16);
        n = 0;
        while (!m_valid16 && n < 200) begin @(negedge clk); n++; end
        gaps = 0;
        for (int i = 0; i < 511; i++) begin @(negedge clk); if (!m_valid16) gaps++; end
        check("t3_throughput_gaps", gaps, 32'd0);
        drain(1'b1, "t3_drain");
        check("t5_frame_done_count", fd_cnt16, 32'd2);

        // test 4: output stalled, only two banks of blocks fit
        rmode16 = 0; acc16 = 0; pop16 = 0;
        push_frame16(16);
        repeat (40) @(negedge clk);
        check("t4_blocks_accepted", acc16, 32'd8);
        check("t4_s_ready_low", {31'd0, s_ready16}, 32'd0);
        rmode16 = 1;
        n = 0;
        while (pop16 < 64 && n < 400) begin @(negedge clk); #1; n++; end
        check("t4_s_ready_before_64th", {31'd0, s_ready16}, 32'd0);
        @(negedge clk); #1;
        check("t4_s_ready_after_64th", {31'd0, s_ready16}, 32'd1);
        drain(1'b1, "t4_drain");

        // test 6: reset in the middle of a row
        acc16 = 0; pop16 = 0; lim16 = 10;
        push_frame16(5);
        n = 0;
        while (pop16 < 10 && n < 400) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check("t6_blocks_before_reset", acc16, 32'd5);
        check("t6_valid_before_reset", {31'd0, m_valid16}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_reset_immediate", {30'd0, m_valid16, s_ready16}, 32'd0);
        blk_q16.delete(); exp_q16.delete(); blk_q4.delete(); exp_q4.delete();
        fire_pend16 = 0; fire_pend4 = 0; hold16 = 0; hold4 = 0; fd_pend16 = 0; fd_pend4 = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rmode4 = 1; lat_arm4 = 1;
        push_t1();
        drain(1'b0, "t6_drain");
        check("t6_latency_seen", {31'd0, lat_arm4}, 32'd0);
        check("t6_no_pixel16", {31'd0, m_valid16}, 32'd0);
        check("frame_done4_count", fd_cnt4, 32'd3);
        check("frame_done16_count", fd_cnt16, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
